pattern_scan_unit: RTL

- Memory-side accelerator for the 5-bit pattern search workload. Runs on the same data memory that the program-3 bench preloads.
- Input region: message bytes in data memory at BASE_ADDR..BASE_ADDR+NUM_BYTES-1 and the pattern byte at PAT_ADDR.
- Computes three counts: in-byte matches, bytes with at least one match, and matches including byte crossings.
- Writes the counts to RES_ADDR..RES_ADDR+2, then raises done. Sits beside top_level's data memory as a bus master on its read/write port.

---
 rtl/pattern_scan_unit_if.sv | 24 ++
 rtl/pattern_scan_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_unit_if.sv
// Bus bundle for pattern_scan_unit: start/done/busy handshake plus the data-memory
// read/write port the unit drives while it owns the memory.
interface pattern_scan_unit_if #(
   parameter int AW = 8
);
   logic          start;
   logic          done;
   logic          busy;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic          mem_wen;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_wdata;

   modport master (
      input  start, mem_rdata,
      output done, busy, mem_addr, mem_wen, mem_waddr, mem_wdata
   );

   modport slave (
      output start, mem_rdata,
      input  done, busy, mem_addr, mem_wen, mem_waddr, mem_wdata
   );
endinterface

// File: rtl/pattern_scan_unit.sv
// 5-bit pattern search accelerator: scans NUM_BYTES message bytes, writes in-byte,
// byte-hit and crossing-inclusive counts. Define PSU_SATURATE_EN for saturating counters.
module pattern_scan_unit #(
   parameter int AW        = 8,
   parameter int BASE_ADDR = 0,
   parameter int NUM_BYTES = 32,
   parameter int PAT_ADDR  = 32,
   parameter int RES_ADDR  = 33
) (
   input  logic clk,
   input  logic reset,
   pattern_scan_unit_if.master bus
);
   localparam int IW = $clog2(NUM_BYTES) + 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD_PAT = 3'd1,
      SCAN     = 3'd2,
      WR_B     = 3'd3,
      WR_O     = 3'd4,
      WR_S     = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [4:0]    pat_q, pat_d;
   logic [3:0]    prev_q, prev_d;
   logic [7:0]    ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d, mem_waddr_q, mem_waddr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;
   logic          mem_wen_q, mem_wen_d, done_q, done_d, busy_q, busy_d;
   logic [7:0]    m_s, x_s;

   // Number of the four 5-bit windows of a byte that equal the pattern.
   function automatic logic [7:0] win_count(input logic [7:0] b, input logic [4:0] p);
      logic [7:0] n;
      n = 8'd0;
      n = n + {7'd0, (b[7:3] == p)};
      n = n + {7'd0, (b[6:2] == p)};
      n = n + {7'd0, (b[5:1] == p)};
      n = n + {7'd0, (b[4:0] == p)};
      return n;
   endfunction

   function automatic logic [7:0] cnt_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef PSU_SATURATE_EN
      if (s[8]) begin
         return 8'hFF;
      end else begin
         return s[7:0];
      end
`else
      return s[7:0];
`endif
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         pat_q       <= 5'd0;
         prev_q      <= 4'd0;
         ctb_q       <= 8'd0;
         cto_q       <= 8'd0;
         cts_q       <= 8'd0;
         mem_addr_q  <= '0;
         mem_waddr_q <= '0;
         mem_wdata_q <= 8'd0;
         mem_wen_q   <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pat_q       <= pat_d;
         prev_q      <= prev_d;
         ctb_q       <= ctb_d;
         cto_q       <= cto_d;
         cts_q       <= cts_d;
         mem_addr_q  <= mem_addr_d;
         mem_waddr_q <= mem_waddr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wen_q   <= mem_wen_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   // Next state; bus outputs are computed for the state being entered so they register cleanly.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pat_d       = pat_q;
      prev_d      = prev_q;
      ctb_d       = ctb_q;
      cto_d       = cto_q;
      cts_d       = cts_q;
      mem_addr_d  = mem_addr_q;
      mem_waddr_d = mem_waddr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wen_d   = 1'b0;
      m_s         = win_count(bus.mem_rdata, pat_q);
      x_s         = 8'd0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d    = LOAD_PAT;
               ctb_d      = 8'd0;
               cto_d      = 8'd0;
               cts_d      = 8'd0;
               mem_addr_d = AW'(PAT_ADDR);
            end else begin
               state_d = state_q;
            end
         end
         LOAD_PAT: begin
            pat_d      = bus.mem_rdata[7:3];
            idx_d      = '0;
            mem_addr_d = AW'(BASE_ADDR);
            state_d    = SCAN;
         end
         SCAN: begin
            // Byte 0 has no predecessor, so it contributes no crossing windows.
            if (idx_q != '0) begin
               x_s = win_count({prev_q, bus.mem_rdata[7:4]}, pat_q);
            end else begin
               x_s = 8'd0;
            end
            ctb_d  = cnt_add(ctb_q, m_s);
            cto_d  = cnt_add(cto_q, {7'd0, (m_s != 8'd0)});
            cts_d  = cnt_add(cnt_add(cts_q, m_s), x_s);
            prev_d = bus.mem_rdata[3:0];
            if (idx_q == IW'(NUM_BYTES - 1)) begin
               state_d     = WR_B;
               mem_wen_d   = 1'b1;
               mem_waddr_d = AW'(RES_ADDR);
               mem_wdata_d = ctb_d;
            end else begin
               idx_d      = idx_q + IW'(1'b1);
               mem_addr_d = AW'(BASE_ADDR) + AW'(idx_q) + AW'(1'b1);
            end
         end
         WR_B: begin
            state_d     = WR_O;
            mem_wen_d   = 1'b1;
            mem_waddr_d = AW'(RES_ADDR + 1);
            mem_wdata_d = cto_q;
         end
         WR_O: begin
            state_d     = WR_S;
            mem_wen_d   = 1'b1;
            mem_waddr_d = AW'(RES_ADDR + 2);
            mem_wdata_d = cts_q;
         end
         WR_S: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE) && (state_d != DONE);
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wen   = mem_wen_q;
   assign bus.mem_waddr = mem_waddr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
endmodule
